// File: rtl/fwd_hazard_unit_if.sv
// Decode-side bundle for fwd_hazard_unit: bypass stages, read ports, issue request and results.
// Stats outputs exist only when FWD_STATS_EN is defined.
interface fwd_hazard_unit_if #(
  parameter int NRD   = 2,
  parameter int NSTG  = 2,
  parameter int XLEN  = 32,
  parameter int RBITS = 5,
  parameter int LAT_W = 3
);
  localparam int SW   = 1 + XLEN + RBITS;
  localparam int NREG = 2 ** RBITS;

  logic [NSTG*SW-1:0]    stg_bus;
  logic [NSTG-1:0]       stg_dvalid;
  logic [NRD*RBITS-1:0]  rs_addr;
  logic [NRD-1:0]        rs_used;
  logic [NRD*XLEN-1:0]   rf_data;
  logic                  issue_valid;
  logic                  issue_wen;
  logic [RBITS-1:0]      issue_rd;
  logic [LAT_W-1:0]      issue_lat;
  logic                  flush;
  logic [NRD*XLEN-1:0]   fwd_data;
  logic                  stall;
  logic                  issue_ack;
  logic [NREG-1:0]       sb_busy;
`ifdef FWD_STATS_EN
  logic [31:0]           stat_stall;
  logic [31:0]           stat_fwd;
`endif

  modport master (
    output stg_bus, stg_dvalid, rs_addr, rs_used, rf_data,
    output issue_valid, issue_wen, issue_rd, issue_lat, flush,
`ifdef FWD_STATS_EN
    input  stat_stall, stat_fwd,
`endif
    input  fwd_data, stall, issue_ack, sb_busy
  );

  modport slave (
    input  stg_bus, stg_dvalid, rs_addr, rs_used, rf_data,
    input  issue_valid, issue_wen, issue_rd, issue_lat, flush,
`ifdef FWD_STATS_EN
    output stat_stall, stat_fwd,
`endif
    output fwd_data, stall, issue_ack, sb_busy
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Decode-stage operand forwarding, load-use detection and long-latency scoreboard.
// Define FWD_STATS_EN to add saturating stall/forward cycle counters.
module fwd_hazard_unit #(
  parameter int NRD   = 2,
  parameter int NSTG  = 2,
  parameter int XLEN  = 32,
  parameter int RBITS = 5,
  parameter int LAT_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  fwd_hazard_unit_if.slave  hz
);
  localparam int SW   = 1 + XLEN + RBITS;
  localparam int NREG = 2 ** RBITS;

  logic [NRD*XLEN-1:0] fwd_data_w;
  logic [NRD-1:0]      port_stall;
  logic [NREG-1:0]     cnt_nz;
  logic [NREG-1:0]     sb_busy_d;
  logic [NREG-1:0]     sb_busy_q;
  logic                waw;
  logic                stall_w;
  logic                ack_w;
  logic                load_en;
`ifdef FWD_STATS_EN
  logic [NRD-1:0]      port_hit;
`endif

  genvar gi;

  generate
    for (gi = 0; gi < NRD; gi++) begin : g_port
      logic [RBITS-1:0] rs;
      logic [XLEN-1:0]  data;
      logic             hit;
      logic             win_dvalid;

      always_comb begin
        rs         = hz.rs_addr[gi*RBITS +: RBITS];
        data       = hz.rf_data[gi*XLEN +: XLEN];
        hit        = 1'b0;
        win_dvalid = 1'b1;
        // Oldest to youngest, so the youngest matching stage is what remains selected.
        for (int i = NSTG - 1; i >= 0; i--) begin
          if (hz.stg_bus[i*SW + SW - 1] && (hz.stg_bus[i*SW +: RBITS] == rs) && (rs != '0)) begin
            hit        = 1'b1;
            data       = hz.stg_bus[i*SW + RBITS +: XLEN];
            win_dvalid = hz.stg_dvalid[i];
          end
        end
      end

      assign fwd_data_w[gi*XLEN +: XLEN] = data;
      assign port_stall[gi] = hz.rs_used[gi] & ((hit & ~win_dvalid) | cnt_nz[rs]);
`ifdef FWD_STATS_EN
      assign port_hit[gi] = hit;
`endif
    end
  endgenerate

  assign waw     = hz.issue_wen & (hz.issue_rd != '0) & cnt_nz[hz.issue_rd];
  assign stall_w = hz.issue_valid & ((|port_stall) | waw);
  assign ack_w   = hz.issue_valid & ~stall_w & ~hz.flush;
  assign load_en = ack_w & hz.issue_wen & (hz.issue_lat != '0);

  // r0 is never tracked, so its entry is permanently idle.
  assign cnt_nz[0]    = 1'b0;
  assign sb_busy_d[0] = 1'b0;

  generate
    for (gi = 1; gi < NREG; gi++) begin : g_cnt
      logic [LAT_W-1:0] cnt_q;
      logic [LAT_W-1:0] cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - LAT_W'(1);
        end
        if (load_en && (hz.issue_rd == RBITS'(gi))) begin
          cnt_d = hz.issue_lat;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign cnt_nz[gi]    = (cnt_q != '0);
      assign sb_busy_d[gi] = (cnt_d != '0);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_busy_q <= '0;
    end else begin
      sb_busy_q <= sb_busy_d;
    end
  end

  assign hz.fwd_data  = fwd_data_w;
  assign hz.stall     = stall_w;
  assign hz.issue_ack = ack_w;
  assign hz.sb_busy   = sb_busy_q;

`ifdef FWD_STATS_EN
  logic [31:0] stat_stall_q;
  logic [31:0] stat_stall_d;
  logic [31:0] stat_fwd_q;
  logic [31:0] stat_fwd_d;

  always_comb begin
    stat_stall_d = stat_stall_q;
    stat_fwd_d   = stat_fwd_q;
    if (stall_w && (stat_stall_q != 32'hFFFF_FFFF)) begin
      stat_stall_d = stat_stall_q + 32'd1;
    end
    if (!stall_w && (|port_hit) && (stat_fwd_q != 32'hFFFF_FFFF)) begin
      stat_fwd_d = stat_fwd_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_stall_q <= '0;
      stat_fwd_q   <= '0;
    end else begin
      stat_stall_q <= stat_stall_d;
      stat_fwd_q   <= stat_fwd_d;
    end
  end

  assign hz.stat_stall = stat_stall_q;
  assign hz.stat_fwd   = stat_fwd_q;
`endif
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: stimulus pushes expected results, a negedge monitor
// pops and compares. Stats checks are included when FWD_STATS_EN is defined.
module tb_fwd_hazard_unit;
  localparam int NRD   = 2;
  localparam int NSTG  = 2;
  localparam int XLEN  = 32;
  localparam int RBITS = 5;
  localparam int LAT_W = 3;
  localparam int SW    = 1 + XLEN + RBITS;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fwd_hazard_unit_if #(.NRD(NRD), .NSTG(NSTG), .XLEN(XLEN), .RBITS(RBITS), .LAT_W(LAT_W)) hz ();

  fwd_hazard_unit #(.NRD(NRD), .NSTG(NSTG), .XLEN(XLEN), .RBITS(RBITS), .LAT_W(LAT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  typedef struct {
    string       name;
    logic        stall;
    logic        ack;
    logic [31:0] fwd0;
    logic [31:0] fwd1;
    bit          chk_f0;
    bit          chk_f1;
    logic [31:0] busy;
    bit          chk_busy;
    logic [31:0] st_stall;
    logic [31:0] st_fwd;
    bit          chk_stat;
  } exp_t;

  exp_t exp_q[$];
  int   n_run  = 0;
  int   n_fail = 0;

  task automatic check(input string txn, input string what, input logic [31:0] act, input logic [31:0] req);
    n_run++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s actual=%h required=%h", txn, what, act, req);
    end
  endtask

  // Monitor: one expectation per cycle, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check(e.name, "stall", 32'(hz.stall), 32'(e.stall));
      check(e.name, "issue_ack", 32'(hz.issue_ack), 32'(e.ack));
      if (e.chk_f0)   check(e.name, "fwd_data0", hz.fwd_data[0 +: XLEN], e.fwd0);
      if (e.chk_f1)   check(e.name, "fwd_data1", hz.fwd_data[XLEN +: XLEN], e.fwd1);
      if (e.chk_busy) check(e.name, "sb_busy", hz.sb_busy, e.busy);
`ifdef FWD_STATS_EN
      if (e.chk_stat) begin
        check(e.name, "stat_stall", hz.stat_stall, e.st_stall);
        check(e.name, "stat_fwd", hz.stat_fwd, e.st_fwd);
      end
`endif
      $display("[TB] txn %s stall=%0b ack=%0b fwd0=%h fwd1=%h busy=%h",
               e.name, hz.stall, hz.issue_ack, hz.fwd_data[0 +: XLEN], hz.fwd_data[XLEN +: XLEN], hz.sb_busy);
    end
  end

  function automatic exp_t mk(input string name, input logic stall, input logic ack);
    exp_t e;
    e.name     = name;
    e.stall    = stall;
    e.ack      = ack;
    e.fwd0     = '0;
    e.fwd1     = '0;
    e.chk_f0   = 1'b0;
    e.chk_f1   = 1'b0;
    e.busy     = '0;
    e.chk_busy = 1'b0;
    e.st_stall = '0;
    e.st_fwd   = '0;
    e.chk_stat = 1'b0;
    return e;
  endfunction

  task automatic txn_begin();
    @(posedge clk);
    #1;
    hz.stg_bus     = '0;
    hz.stg_dvalid  = '1;
    hz.rs_addr     = '0;
    hz.rs_used     = '0;
    hz.rf_data     = '0;
    hz.issue_valid = 1'b0;
    hz.issue_wen   = 1'b0;
    hz.issue_rd    = '0;
    hz.issue_lat   = '0;
    hz.flush       = 1'b0;
  endtask

  task automatic set_stg(input int i, input logic wen, input logic [31:0] data, input logic [4:0] rd);
    hz.stg_bus[i*SW +: SW] = {wen, data, rd};
  endtask

  task automatic set_rs(input int p, input logic [4:0] rs, input logic used, input logic [31:0] rf);
    hz.rs_addr[p*RBITS +: RBITS] = rs;
    hz.rs_used[p]                = used;
    hz.rf_data[p*XLEN +: XLEN]   = rf;
  endtask

  task automatic set_issue(input logic v, input logic wen, input logic [4:0] rd, input logic [2:0] lat);
    hz.issue_valid = v;
    hz.issue_wen   = wen;
    hz.issue_rd    = rd;
    hz.issue_lat   = lat;
  endtask

  task automatic load_use_r9();
    set_stg(0, 1'b1, 32'hDEAD, 5'd9);
    hz.stg_dvalid = 2'b10;
    set_rs(0, 5'd9, 1'b1, 32'h0);
    set_issue(1'b1, 1'b0, 5'd0, 3'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time_limit actual=expired required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    hz.stg_bus = '0; hz.stg_dvalid = '1; hz.rs_addr = '0; hz.rs_used = '0; hz.rf_data = '0;
    hz.issue_valid = 1'b0; hz.issue_wen = 1'b0; hz.issue_rd = '0; hz.issue_lat = '0; hz.flush = 1'b0;

    // Reset state
    txn_begin();
    e = mk("reset", 1'b0, 1'b0); e.chk_f0 = 1; e.chk_f1 = 1; e.chk_busy = 1; exp_q.push_back(e);

    // Forward priority
    txn_begin(); rst_n = 1'b1;
    set_stg(0, 1'b1, 32'hAAAA, 5'd5); set_stg(1, 1'b1, 32'hBBBB, 5'd5);
    set_rs(0, 5'd5, 1'b1, 32'h1111); set_rs(1, 5'd0, 1'b1, 32'h2222); set_issue(1'b1, 1'b0, 5'd0, 3'd0);
    e = mk("prio_s0", 1'b0, 1'b1); e.fwd0 = 32'hAAAA; e.chk_f0 = 1; e.fwd1 = 32'h2222; e.chk_f1 = 1; exp_q.push_back(e);

    txn_begin();
    set_stg(0, 1'b0, 32'hAAAA, 5'd5); set_stg(1, 1'b1, 32'hBBBB, 5'd5);
    set_rs(0, 5'd5, 1'b1, 32'h1111); set_issue(1'b1, 1'b0, 5'd0, 3'd0);
    e = mk("prio_s1", 1'b0, 1'b1); e.fwd0 = 32'hBBBB; e.chk_f0 = 1; exp_q.push_back(e);

    txn_begin();
    set_stg(0, 1'b0, 32'hAAAA, 5'd5); set_stg(1, 1'b0, 32'hBBBB, 5'd5);
    set_rs(0, 5'd5, 1'b1, 32'h1111); set_issue(1'b1, 1'b0, 5'd0, 3'd0);
    e = mk("no_hit", 1'b0, 1'b1); e.fwd0 = 32'h1111; e.chk_f0 = 1; exp_q.push_back(e);

    // r0 and unused port
    txn_begin();
    set_stg(0, 1'b1, 32'h1234, 5'd0);
    e = mk("r0", 1'b0, 1'b0); e.chk_f0 = 1; e.chk_f1 = 1; exp_q.push_back(e);

    txn_begin();
    set_stg(0, 1'b1, 32'h5555, 5'd7); hz.stg_dvalid = 2'b10;
    set_rs(0, 5'd7, 1'b0, 32'h0); set_issue(1'b1, 1'b0, 5'd0, 3'd0);
    e = mk("unused_lu", 1'b0, 1'b1); e.fwd0 = 32'h5555; e.chk_f0 = 1; exp_q.push_back(e);

    // Load-use
    txn_begin();
    set_stg(0, 1'b1, 32'hDEAD, 5'd9); set_stg(1, 1'b1, 32'hBEEF, 5'd9); hz.stg_dvalid = 2'b10;
    set_rs(1, 5'd9, 1'b1, 32'h7777); set_issue(1'b1, 1'b0, 5'd0, 3'd0);
    e = mk("load_use", 1'b1, 1'b0); exp_q.push_back(e);

    txn_begin();
    set_stg(0, 1'b1, 32'hCAFE, 5'd9); set_stg(1, 1'b1, 32'hBEEF, 5'd9);
    set_rs(1, 5'd9, 1'b1, 32'h7777); set_issue(1'b1, 1'b0, 5'd0, 3'd0);
    e = mk("load_done", 1'b0, 1'b1); e.fwd1 = 32'hCAFE; e.chk_f1 = 1; exp_q.push_back(e);

    txn_begin();
    set_stg(0, 1'b1, 32'hDEAD, 5'd9); hz.stg_dvalid = 2'b10; set_rs(1, 5'd9, 1'b1, 32'h7777);
    e = mk("lu_noissue", 1'b0, 1'b0); exp_q.push_back(e);

    txn_begin();
    set_stg(0, 1'b1, 32'hDEAD, 5'd9); hz.stg_dvalid = 2'b10; set_rs(1, 5'd9, 1'b1, 32'h7777);
    set_issue(1'b1, 1'b0, 5'd0, 3'd0); hz.flush = 1'b1;
    e = mk("lu_flush", 1'b1, 1'b0); exp_q.push_back(e);

    txn_begin();
    set_issue(1'b1, 1'b0, 5'd0, 3'd0); hz.flush = 1'b1;
    e = mk("flush_only", 1'b0, 1'b0); exp_q.push_back(e);

    txn_begin();
    set_stg(1, 1'b1, 32'hBEEF, 5'd9); hz.stg_dvalid = 2'b01;
    set_rs(1, 5'd9, 1'b1, 32'h7777); set_issue(1'b1, 1'b0, 5'd0, 3'd0);
    e = mk("lu_old", 1'b1, 1'b0); e.fwd1 = 32'hBEEF; e.chk_f1 = 1; exp_q.push_back(e);

    // Long-latency op to r12
    txn_begin(); set_issue(1'b1, 1'b1, 5'd12, 3'd4);
    e = mk("lop_issue", 1'b0, 1'b1); e.chk_busy = 1; exp_q.push_back(e);

    txn_begin(); set_issue(1'b1, 1'b1, 5'd12, 3'd2);
    e = mk("waw", 1'b1, 1'b0); e.busy = 32'h1 << 12; e.chk_busy = 1; exp_q.push_back(e);

    for (int k = 0; k < 3; k++) begin
      txn_begin(); set_rs(0, 5'd12, 1'b1, 32'h0); set_issue(1'b1, 1'b0, 5'd0, 3'd0);
      e = mk($sformatf("raw_%0d", k), 1'b1, 1'b0); e.busy = 32'h1 << 12; e.chk_busy = 1; exp_q.push_back(e);
    end

    txn_begin(); set_stg(0, 1'b1, 32'h600D, 5'd12);
    set_rs(0, 5'd12, 1'b1, 32'h0); set_issue(1'b1, 1'b0, 5'd0, 3'd0);
    e = mk("raw_go", 1'b0, 1'b1); e.fwd0 = 32'h600D; e.chk_f0 = 1; e.chk_busy = 1; exp_q.push_back(e);

    // r0 destination and zero latency leave the table alone
    txn_begin(); set_issue(1'b1, 1'b1, 5'd0, 3'd5);
    e = mk("r0_write", 1'b0, 1'b1); e.chk_busy = 1; exp_q.push_back(e);

    txn_begin(); set_issue(1'b1, 1'b1, 5'd20, 3'd0);
    e = mk("lat0", 1'b0, 1'b1); e.chk_busy = 1; exp_q.push_back(e);

    txn_begin(); set_issue(1'b1, 1'b1, 5'd20, 3'd3);
    e = mk("lat3", 1'b0, 1'b1); e.chk_busy = 1; exp_q.push_back(e);

    txn_begin(); set_issue(1'b1, 1'b0, 5'd0, 3'd0); hz.flush = 1'b1;
    e = mk("flush_keep", 1'b0, 1'b0); e.busy = 32'h1 << 20; e.chk_busy = 1; exp_q.push_back(e);

    txn_begin(); set_rs(1, 5'd20, 1'b1, 32'h0); set_issue(1'b1, 1'b0, 5'd0, 3'd0);
    e = mk("raw20", 1'b1, 1'b0); e.busy = 32'h1 << 20; e.chk_busy = 1; exp_q.push_back(e);

    // Reset mid-operation
    txn_begin(); set_issue(1'b1, 1'b1, 5'd3, 3'd5);
    e = mk("rst_issue", 1'b0, 1'b1); e.busy = 32'h1 << 20; e.chk_busy = 1; exp_q.push_back(e);

    txn_begin(); set_rs(0, 5'd3, 1'b1, 32'h0); set_issue(1'b1, 1'b0, 5'd0, 3'd0);
    e = mk("rst_pre", 1'b1, 1'b0); e.busy = 32'h1 << 3; e.chk_busy = 1; exp_q.push_back(e);

    txn_begin(); set_rs(0, 5'd3, 1'b1, 32'h0); set_issue(1'b1, 1'b0, 5'd0, 3'd0);
    e = mk("rst_async", 1'b0, 1'b1); e.chk_busy = 1; exp_q.push_back(e);
    #2 rst_n = 1'b0;

    txn_begin(); rst_n = 1'b1;
    set_rs(0, 5'd3, 1'b1, 32'h0); set_issue(1'b1, 1'b0, 5'd0, 3'd0);
    e = mk("rst_after", 1'b0, 1'b1); e.chk_busy = 1; exp_q.push_back(e);

`ifdef FWD_STATS_EN
    for (int k = 0; k < 10; k++) begin
      txn_begin(); load_use_r9();
      e = mk($sformatf("st_stall_%0d", k), 1'b1, 1'b0); exp_q.push_back(e);
    end
    for (int k = 0; k < 7; k++) begin
      txn_begin(); set_stg(0, 1'b1, 32'h0F0F, 5'd9);
      set_rs(0, 5'd9, 1'b1, 32'h0); set_issue(1'b1, 1'b0, 5'd0, 3'd0);
      e = mk($sformatf("st_fwd_%0d", k), 1'b0, 1'b1); e.fwd0 = 32'h0F0F; e.chk_f0 = 1; exp_q.push_back(e);
    end
    txn_begin();
    e = mk("stats", 1'b0, 1'b0); e.st_stall = 32'd10; e.st_fwd = 32'd7; e.chk_stat = 1; exp_q.push_back(e);

    txn_begin(); force dut.stat_stall_q = 32'hFFFF_FFFF; load_use_r9();
    e = mk("sat_0", 1'b1, 1'b0); exp_q.push_back(e);
    txn_begin(); release dut.stat_stall_q; load_use_r9();
    e = mk("sat_1", 1'b1, 1'b0); exp_q.push_back(e);
    txn_begin(); load_use_r9();
    e = mk("sat_2", 1'b1, 1'b0); exp_q.push_back(e);
    txn_begin();
    e = mk("sat_chk", 1'b0, 1'b0); e.st_stall = 32'hFFFF_FFFF; e.st_fwd = 32'd7; e.chk_stat = 1; exp_q.push_back(e);
`endif

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
    #1;
    n_run++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
